// File: rtl/karaoke_pkg.sv
// Shared types and helpers for the mic front end: Q15 sample type, its
// limits, and the CIC register width rule.
package karaoke_pkg;

  typedef logic signed [15:0] sample_t;

  localparam sample_t Q15_MAX = 16'sh7fff;
  localparam sample_t Q15_MIN = 16'sh8000;

  // Bit growth of an N-stage, differential-delay-1 CIC decimating by r
  function automatic int cic_width(input int n, input int r);
    return 2 + n * $clog2(r);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb stage: y = x - x_prev, the delay register only moving when
// the decimated-rate token reaches this stage.
module cic_comb_stage #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en_stage,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  logic [W-1:0] prev_q, prev_d;

  always_comb begin
    prev_d = prev_q;
    if (clr)           prev_d = '0;
    else if (en_stage) prev_d = x;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_q <= '0;
    else          prev_q <= prev_d;
  end

  assign y = x - prev_q;

endmodule

// File: rtl/pdm_cic_decim.sv
// PDM mic front end: mic clock generation, input synchroniser, N-stage CIC
// decimator by R, Q15 scaling/saturation and warm-up suppression.
module pdm_cic_decim
  import karaoke_pkg::*;
#(
  parameter int CLK_DIV = 24,
  parameter int R       = 32,
  parameter int N       = 4,
  parameter int OUT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    pdm_data,
  output logic                    pdm_clk,
  output logic signed [OUT_W-1:0] y_out,
  output logic                    y_out_valid
);

  localparam int W      = cic_width(N, R);
  localparam int SHIFT  = N * $clog2(R) - (OUT_W - 1);
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int DEC_W  = $clog2(R);
  localparam int WARM_W = $clog2(N + 1);

  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [DEC_W-1:0]    DEC_LAST  = DEC_W'(R - 1);
  localparam logic [WARM_W-1:0]   WARM_DONE = WARM_W'(N);
  localparam logic signed [W-1:0] SAT_MAX   = W'(Q15_MAX);
  localparam logic signed [W-1:0] SAT_MIN   = W'(Q15_MIN);

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              pdm_clk_q, pdm_clk_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DEC_W-1:0]  dec_cnt_q, dec_cnt_d;
  logic [W-1:0]      integ_q [N];
  logic [W-1:0]      integ_d [N];
  logic [W-1:0]      pipe_q  [N+1];
  logic [W-1:0]      pipe_d  [N+1];
  logic [N:0]        vld_q, vld_d;
  logic [W-1:0]      comb_y  [N];
  logic [WARM_W-1:0] warm_q, warm_d;
  logic signed [OUT_W-1:0] y_out_q, y_out_d;
  logic              y_out_valid_q, y_out_valid_d;

  logic              strobe, wrap;
  logic [W-1:0]      x_in, integ_sum;
  logic signed [W-1:0] scaled;
  sample_t           y_sat;

  // pipe_q[k] feeds comb k; vld_q[k] marks a decimated sample sitting there
  for (genvar k = 0; k < N; k++) begin : g_comb
    cic_comb_stage #(.W(W)) u_comb (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (!en),
      .en_stage (vld_q[k]),
      .x        (pipe_q[k]),
      .y        (comb_y[k])
    );
  end

  always_comb begin
    scaled = $signed(pipe_q[N]) >>> SHIFT;
    if (scaled > SAT_MAX)      y_sat = Q15_MAX;
    else if (scaled < SAT_MIN) y_sat = Q15_MIN;
    else                       y_sat = scaled[15:0];
  end

  always_comb begin
    div_cnt_d     = '0;
    pdm_clk_d     = 1'b0;
    sync1_d       = 1'b0;
    sync2_d       = 1'b0;
    dec_cnt_d     = '0;
    vld_d         = '0;
    warm_d        = '0;
    y_out_d       = y_out_q;
    y_out_valid_d = 1'b0;
    strobe        = 1'b0;
    wrap          = 1'b0;
    integ_sum     = '0;
    x_in          = sync2_q ? W'(1) : '1;
    for (int k = 0; k < N; k++)  integ_d[k] = '0;
    for (int k = 0; k <= N; k++) pipe_d[k]  = '0;

    if (en) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
      pdm_clk_d = (div_cnt_d < DIV_HALF);
      sync1_d   = pdm_data;
      sync2_d   = sync1_q;
      strobe    = (div_cnt_q == DIV_LAST);
      wrap      = strobe && (dec_cnt_q == DEC_LAST);
      dec_cnt_d = dec_cnt_q;
      warm_d    = warm_q;
      integ_d   = integ_q;
      pipe_d    = pipe_q;

      // Integrators ripple within one clk so each sees this sample
      if (strobe) begin
        dec_cnt_d = wrap ? '0 : dec_cnt_q + 1'b1;
        integ_sum = x_in;
        for (int k = 0; k < N; k++) begin
          integ_sum  = integ_q[k] + integ_sum;
          integ_d[k] = integ_sum;
        end
      end

      if (wrap) pipe_d[0] = integ_d[N-1];
      for (int k = 0; k < N; k++) begin
        if (vld_q[k]) pipe_d[k+1] = comb_y[k];
      end
      vld_d = {vld_q[N-1:0], wrap};

      if (vld_q[N]) begin
        if (warm_q == WARM_DONE) begin
          y_out_valid_d = 1'b1;
          y_out_d       = OUT_W'(y_sat);
        end else begin
          warm_d = warm_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q     <= '0;
      pdm_clk_q     <= 1'b0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      dec_cnt_q     <= '0;
      vld_q         <= '0;
      warm_q        <= '0;
      y_out_q       <= '0;
      y_out_valid_q <= 1'b0;
      for (int k = 0; k < N; k++)  integ_q[k] <= '0;
      for (int k = 0; k <= N; k++) pipe_q[k]  <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pdm_clk_q     <= pdm_clk_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      dec_cnt_q     <= dec_cnt_d;
      vld_q         <= vld_d;
      warm_q        <= warm_d;
      y_out_q       <= y_out_d;
      y_out_valid_q <= y_out_valid_d;
      integ_q       <= integ_d;
      pipe_q        <= pipe_d;
    end
  end

  assign pdm_clk     = pdm_clk_q;
  assign y_out       = y_out_q;
  assign y_out_valid = y_out_valid_q;

endmodule

// File: tb/tb_pdm_cic_decim.sv
// Bench for pdm_cic_decim: drives PDM bits on each mic clock rise and checks
// every output pulse against a direct boxcar^N convolution of the bit history.
module tb_pdm_cic_decim;

  localparam int CLK_DIV = 24;
  localparam int R       = 32;
  localparam int N       = 4;
  localparam int OUT_W   = 16;
  localparam int BLK     = CLK_DIV * R;
  localparam int SHIFT   = N * $clog2(R) - (OUT_W - 1);
  localparam int HLEN    = N * (R - 1) + 1;
  localparam int FIRST_T = BLK * (N + 1) + N + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic pdm_data = 1'b0;
  logic pdm_clk;
  logic signed [OUT_W-1:0] y_out;
  logic y_out_valid;

  pdm_cic_decim #(.CLK_DIV(CLK_DIV), .R(R), .N(N), .OUT_W(OUT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .pdm_data    (pdm_data),
    .pdm_clk     (pdm_clk),
    .y_out       (y_out),
    .y_out_valid (y_out_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int mode = 0;
  int dens = 50;
  int en_cyc = 0;
  int pdm_rises = 0;
  int first_t = 0;
  bit xs[$];
  int pv_y[$];
  int pv_t[$];
  longint h[HLEN];

  // clk edges since the run started (en high and out of reset)
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)  en_cyc <= 0;
    else if (!en)  en_cyc <= 0;
    else           en_cyc <= en_cyc + 1;
  end

  always @(negedge clk) begin
    if (y_out_valid) begin
      pv_y.push_back(int'(y_out));
      pv_t.push_back(en_cyc);
    end
  end

  function automatic bit gen_bit(int idx);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (idx % 2) == 0;
      3:       return (idx % 4) != 3;
      default: return $urandom_range(0, 99) < dens;
    endcase
  endfunction

  // The mic drives a new bit just after each pdm_clk rise
  initial begin
    forever begin
      @(posedge pdm_clk);
      pdm_rises++;
      #1;
      pdm_data = gen_bit(xs.size());
      xs.push_back(pdm_data);
    end
  end

  function automatic void init_h();
    longint tmp[HLEN];
    for (int i = 0; i < HLEN; i++) h[i] = (i == 0) ? 1 : 0;
    for (int s = 0; s < N; s++) begin
      for (int i = 0; i < HLEN; i++) begin
        tmp[i] = 0;
        for (int m = 0; m < R; m++) if (i - m >= 0) tmp[i] += h[i - m];
      end
      for (int i = 0; i < HLEN; i++) h[i] = tmp[i];
    end
  endfunction

  // Expected output for decimated block j (ends at sample j*R+R-1)
  function automatic int model_y(int j);
    longint acc = 0;
    int n = j * R + R - 1;
    for (int i = 0; i < HLEN; i++) begin
      if (n - i >= 0 && n - i < xs.size())
        acc += h[i] * (xs[n - i] ? 64'sd1 : -64'sd1);
    end
    acc = acc >>> SHIFT;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  task automatic check(string tag, int idx, int obs, int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, obs, exp);
    end
  endtask

  task automatic start_run(int m);
    mode = m;
    xs.delete();
    pv_y.delete();
    pv_t.delete();
    @(negedge clk);
    en = 1'b1;
  endtask

  task automatic stop_run();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_pulses(string tag, int n);
    int c = 0;
    while (pv_y.size() < n && c < BLK * (N + 2 + n)) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_count"}, n, pv_y.size(), n);
  endtask

  task automatic check_run(string tag, int n, bit use_fixed, int fixed);
    for (int k = 0; k < n && k < pv_y.size(); k++) begin
      check({tag, "_model"}, k, pv_y[k], model_y(N + k));
      if (use_fixed) check({tag, "_value"}, k, pv_y[k], fixed);
      check({tag, "_time"}, k, pv_t[k], FIRST_T + BLK * k);
      if (k > 0) check({tag, "_spacing"}, k, pv_t[k] - pv_t[k-1], BLK);
    end
  endtask

  initial begin
    int rises0, target, c, last_y;
    init_h();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_y_out", 0, int'(y_out), 0);
    check("rst_valid", 0, int'(y_out_valid), 0);
    check("rst_pdm_clk", 0, int'(pdm_clk), 0);
    reset_n = 1'b1;

    // Idle with en low
    rises0 = pdm_rises;
    repeat (1000) @(negedge clk);
    check("idle_pdm_rises", 0, pdm_rises - rises0, 0);
    check("idle_pulses", 0, pv_y.size(), 0);
    check("idle_y_out", 0, int'(y_out), 0);

    // Full-scale positive, first pulse timing defines the reference
    start_run(0);
    wait_pulses("const1", 3);
    check_run("const1", 3, 1'b1, 32767);
    if (pv_t.size() > 0) first_t = pv_t[0];
    stop_run();

    start_run(1);
    wait_pulses("const0", 2);
    check_run("const0", 2, 1'b1, -32768);
    stop_run();

    start_run(2);
    wait_pulses("alt", 2);
    check_run("alt", 2, 1'b1, 0);
    stop_run();

    // 75% density; integrators wrap during this run
    start_run(3);
    wait_pulses("p1110", 2);
    check_run("p1110", 2, 1'b0, 0);
    for (int k = 0; k < pv_y.size() && k < 2; k++)
      check("p1110_near_16384", k, int'(pv_y[k] >= 16383 && pv_y[k] <= 16385), 1);
    stop_run();

    dens = 30;
    start_run(4);
    wait_pulses("rand30", 3);
    check_run("rand30", 3, 1'b0, 0);
    stop_run();

    dens = 80;
    start_run(4);
    wait_pulses("rand80", 3);
    check_run("rand80", 3, 1'b0, 0);
    stop_run();

    // Drop en one clk after a block wrap: that sample must be lost
    dens = 60;
    start_run(4);
    wait_pulses("drop_pre", 1);
    last_y = (pv_y.size() > 0) ? pv_y[0] : 0;
    target = BLK * (N + 2) + 1;
    c = 0;
    while (en_cyc != target && c < 2 * BLK) begin
      @(negedge clk);
      c++;
    end
    check("drop_sync", 0, en_cyc, target);
    en = 1'b0;
    rises0 = pdm_rises;
    repeat (50) @(negedge clk);
    check("drop_no_pulse", 0, pv_y.size(), 1);
    check("drop_y_hold", 0, int'(y_out), last_y);
    check("drop_pdm_clk", 0, int'(pdm_clk), 0);
    check("drop_pdm_rises", 0, pdm_rises - rises0, 0);
    start_run(4);
    wait_pulses("drop_post", 2);
    check_run("drop_post", 2, 1'b0, 0);

    // Async reset mid-block, en left high
    stop_run();
    start_run(3);
    wait_pulses("arst_pre", 1);
    repeat (300) @(negedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_y_out", 0, int'(y_out), 0);
    check("arst_valid", 0, int'(y_out_valid), 0);
    check("arst_pdm_clk", 0, int'(pdm_clk), 0);
    xs.delete();
    pv_y.delete();
    pv_t.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_pulses("arst_post", 2);
    check_run("arst_post", 2, 1'b1, 16384);
    if (pv_t.size() > 0) check("arst_first_time", 0, pv_t[0], first_t);
    stop_run();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
